serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell. It is the sequential inverse companion to the combinational full-adder cell: same bit-level arithmetic, reversed operation, with a start/done handshake. It sits in the arithmetic library as the area-minimal subtract path for wide operands.

---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/serial_subtractor_fullsubtractor.sv | 16 +
 rtl/serial_subtractor.sv | 120 ++++++++++++
 tb/tb_serial_subtractor.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  // Default operand and result width in bits.
  localparam int SERIAL_SUB_WIDTH = 8;

  // Handshake / sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Width of the bit counter that walks through WIDTH bit positions.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// Single-bit full subtractor: Diff = In1 - In2 - Bin, with borrow out.
module fullsubtractor (
  input  logic In1,
  input  logic In2,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  // A borrow is generated when In1 < In2 and propagated when In1 == In2.
  always_comb begin
    Diff = In1 ^ In2 ^ Bin;
    Bout = (~In1 & In2) | (~(In1 ^ In2) & Bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell.
// Optional build macro: SERIAL_SUB_SAT_EN (unsigned saturation to zero on
// final borrow). Latency and handshake are the same in both builds.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sub_state_t       state_reg;
  sub_state_t       state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             br_reg;

  logic             bit_d;
  logic             bit_bo;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] final_diff;

  // The only arithmetic cell; it always looks at the operand LSBs.
  fullsubtractor u_cell (
    .In1  (a_reg[0]),
    .In2  (b_reg[0]),
    .Bin  (br_reg),
    .Diff (bit_d),
    .Bout (bit_bo)
  );

  assign accept   = (state_reg == IDLE) && Start;
  assign last_bit = (state_reg == RUN) && (cnt_reg == LAST_BIT);
  assign res_next = {bit_d, res_reg[WIDTH-1:1]};

  // Final value loaded into Diff on the completing edge.
  always_comb begin
`ifdef SERIAL_SUB_SAT_EN
    final_diff = bit_bo ? '0 : res_next;
`else
    final_diff = res_next;
`endif
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: start only from IDLE, finish on the last bit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (cnt_reg == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    Ready = (state_reg == IDLE);
    Busy  = (state_reg == RUN) || (state_reg == DONE);
    Done  = (state_reg == DONE);
  end

  // Datapath: capture on accept, shift one bit per RUN cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_reg <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      br_reg  <= 1'b0;
    end else if (accept) begin
      cnt_reg <= '0;
      a_reg   <= A;
      b_reg   <= B;
      res_reg <= '0;
      br_reg  <= Bin;
    end else if (state_reg == RUN) begin
      cnt_reg <= cnt_reg + 1'b1;
      a_reg   <= {1'b0, a_reg[WIDTH-1:1]};
      b_reg   <= {1'b0, b_reg[WIDTH-1:1]};
      res_reg <= res_next;
      br_reg  <= bit_bo;
    end
  end

  // Result registers change only on completion (or reset).
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Diff <= '0;
      Bout <= 1'b0;
    end else if (last_bit) begin
      Diff <= final_diff;
      Bout <= bit_bo;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

  logic       Clk;
  logic       Rst;
  logic       Start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bin;
  logic       Ready;
  logic       Busy;
  logic       Done;
  logic [7:0] Diff;
  logic       Bout;

  int tests;
  int failed;

  serial_subtractor #(.WIDTH(8)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .Ready (Ready),
    .Busy  (Busy),
    .Done  (Done),
    .Diff  (Diff),
    .Bout  (Bout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, wait (bounded) for Done, check results and handshake.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb);
    int cyc;
    bit seen;
    A = a; B = b; Bin = bin; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk({name, "_busy_run"}, {31'd0, Busy}, 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge Clk); #1;
      cyc++;
      if (Done) seen = 1'b1;
    end
    chk({name, "_latency"}, cyc, 32'd8);
    chk({name, "_diff"}, {24'd0, Diff}, {24'd0, ed});
    chk({name, "_bout"}, {31'd0, Bout}, {31'd0, eb});
    chk({name, "_ready_in_done"}, {31'd0, Ready}, 32'd0);
    @(posedge Clk); #1;
    chk({name, "_ready_after"}, {31'd0, Ready}, 32'd1);
    chk({name, "_done_pulse"}, {31'd0, Done}, 32'd0);
    $display("[TB] op %s A=%0d B=%0d Bin=%0d -> Diff=%0h Bout=%0d latency=%0d",
             name, a, b, bin, Diff, Bout, cyc);
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [7:0] exp_under;
    logic [7:0] exp_wrap;
    tests  = 0;
    failed = 0;
`ifdef SERIAL_SUB_SAT_EN
    exp_under = 8'h00;
    exp_wrap  = 8'h00;
`else
    exp_under = 8'hFC;
    exp_wrap  = 8'hFF;
`endif
    Rst = 1'b1; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;

    // Reset held two cycles
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    chk("rst_ready", {31'd0, Ready}, 32'd1);
    chk("rst_busy",  {31'd0, Busy},  32'd0);
    chk("rst_done",  {31'd0, Done},  32'd0);
    chk("rst_diff",  {24'd0, Diff},  32'd0);
    chk("rst_bout",  {31'd0, Bout},  32'd0);
    $display("[TB] reset Ready=%0d Busy=%0d Done=%0d Diff=%0h Bout=%0d", Ready, Busy, Done, Diff, Bout);

    run_op("nominal",   8'd100, 8'd37, 1'b0, 8'd63, 1'b0);
    run_op("underflow", 8'd5,   8'd9,  1'b0, exp_under, 1'b1);
    run_op("bin_wrap",  8'd0,   8'd0,  1'b1, exp_wrap,  1'b1);

    // Ignored Start in RUN cycle 3 and in DONE
    A = 8'd200; B = 8'd1; Bin = 1'b0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge Clk); #1;
      cyc++;
      if (cyc == 3) begin A = 8'd1; B = 8'd1; Start = 1'b1; end
      else Start = 1'b0;
      if (Done) seen = 1'b1;
    end
    chk("ign_latency", cyc, 32'd8);
    chk("ign_diff", {24'd0, Diff}, 32'd199);
    chk("ign_bout", {31'd0, Bout}, 32'd0);
    Start = 1'b1;                      // Start held during DONE
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("ign_ready_after", {31'd0, Ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      if (Done || Busy) seen = 1'b1;
    end
    chk("ign_no_second_op", {31'd0, seen}, 32'd0);
    chk("ign_diff_hold", {24'd0, Diff}, 32'd199);
    $display("[TB] op ignored_start A=200 B=1 -> Diff=%0d Bout=%0d latency=%0d", Diff, Bout, cyc);

    // Reset mid-run at RUN cycle 4
    A = 8'd50; B = 8'd20; Bin = 1'b0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    chk("midrst_ready", {31'd0, Ready}, 32'd1);
    chk("midrst_busy",  {31'd0, Busy},  32'd0);
    chk("midrst_diff",  {24'd0, Diff},  32'd0);
    chk("midrst_bout",  {31'd0, Bout},  32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      if (Done) seen = 1'b1;
    end
    chk("midrst_no_done", {31'd0, seen}, 32'd0);
    $display("[TB] op reset_mid_run A=50 B=20 -> Ready=%0d Diff=%0h", Ready, Diff);
    run_op("after_rst", 8'd50, 8'd20, 1'b0, 8'd30, 1'b0);

    // Reset and Start on the same edge: reset wins
    A = 8'd9; B = 8'd3; Start = 1'b1; Rst = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; Rst = 1'b0;
    chk("rst_start_ready", {31'd0, Ready}, 32'd1);
    chk("rst_start_busy",  {31'd0, Busy},  32'd0);
    chk("rst_start_diff",  {24'd0, Diff},  32'd0);
    $display("[TB] op reset_with_start -> Ready=%0d Busy=%0d Diff=%0h", Ready, Busy, Diff);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
